// File: rtl/multi_port_queue_if.sv
// -----------------------------------------------------------------------------
// multi_port_queue_if
// Lane-parallel enqueue/dequeue bundle for multi_port_queue.
//
// Handshake (both directions): a lane transfers on a rising clk edge exactly
// when its valid and ready are both high at that edge. Lane 0 is the oldest.
// Producer valids and consumer readys must be prefix-contiguous: lane i set
// implies every lane below i is set. The queue's ready/valid outputs come from
// registered state only, so the other side may compute its inputs from them
// within the same cycle.
//
// Signals:
//   enq_valid_i [ENQ_W]        producer -> queue, per-lane enqueue request
//   enq_data_i  [ENQ_W*WIDTH]  producer -> queue, lane i at [i*WIDTH +: WIDTH]
//   enq_ready_o [ENQ_W]        queue -> producer, lane i may enqueue
//   deq_valid_o [DEQ_W]        queue -> consumer, lane j holds an entry
//   deq_data_o  [DEQ_W*WIDTH]  queue -> consumer, lane j at [j*WIDTH +: WIDTH]
//   deq_ready_i [DEQ_W]        consumer -> queue, lane j is taken
// Modports: master = producer/consumer side, slave = the queue.
// -----------------------------------------------------------------------------
interface multi_port_queue_if #(
   parameter int WIDTH = 32,
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2
);
   logic [ENQ_W-1:0]       enq_valid_i;
   logic [ENQ_W*WIDTH-1:0] enq_data_i;
   logic [ENQ_W-1:0]       enq_ready_o;
   logic [DEQ_W-1:0]       deq_valid_o;
   logic [DEQ_W*WIDTH-1:0] deq_data_o;
   logic [DEQ_W-1:0]       deq_ready_i;

   modport master (
      output enq_valid_i, enq_data_i, deq_ready_i,
      input  enq_ready_o, deq_valid_o, deq_data_o
   );

   modport slave (
      input  enq_valid_i, enq_data_i, deq_ready_i,
      output enq_ready_o, deq_valid_o, deq_data_o
   );
endinterface

// File: rtl/multi_port_queue.sv
// -----------------------------------------------------------------------------
// multi_port_queue
// Multi-lane circular FIFO: accepts up to ENQ_W entries and releases up to
// DEQ_W entries per cycle in strict program order. DEPTH need not be a power
// of two. Used as the fetch-to-decode buffer and general multi-issue buffer.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset (same effect as flush_i)
//   flush_i        drop all contents; wins over enqueue and dequeue
//   q_if           enqueue/dequeue lanes (multi_port_queue_if.slave)
//   count_o        current occupancy
//   empty_o        count_o == 0
//   full_o         count_o == DEPTH
//   almost_full_o  free slots <= AFULL_MARGIN
// All outputs depend on registered state only; writes become visible on the
// dequeue side one cycle later (no bypass).
// -----------------------------------------------------------------------------
module multi_port_queue #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 16,
   parameter int ENQ_W        = 2,
   parameter int DEQ_W        = 2,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   multi_port_queue_if.slave          q_if,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_full_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]       r_mem [DEPTH];
   logic [PTR_W-1:0]       r_head;
   logic [PTR_W-1:0]       r_tail;
   logic [CNT_W-1:0]       r_count;

   logic [CNT_W-1:0]       w_free;
   logic [CNT_W-1:0]       w_n_enq;
   logic [CNT_W-1:0]       w_n_deq;
   logic [ENQ_W-1:0]       w_enq_ready;
   logic [ENQ_W-1:0]       w_enq_acc;
   logic [DEQ_W-1:0]       w_deq_valid;
   logic [DEQ_W-1:0]       w_deq_acc;
   logic [DEQ_W*WIDTH-1:0] w_deq_data;

   // Modulo-DEPTH advance. ptr < DEPTH and k <= DEPTH, so a single
   // conditional subtract is enough, also for non-power-of-two DEPTH.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= DEPTH) s = s - DEPTH;
      return s[PTR_W-1:0];
   endfunction

   always_comb begin
      w_free = CNT_W'(DEPTH) - r_count;

      // Ready is based on the registered count only; slots freed by a
      // same-cycle dequeue are not offered to the producer.
      for (int i = 0; i < ENQ_W; i++) w_enq_ready[i] = (int'(w_free) > i);
      w_enq_acc = q_if.enq_valid_i & w_enq_ready;
      w_n_enq   = '0;
      for (int i = 0; i < ENQ_W; i++) w_n_enq = w_n_enq + CNT_W'(w_enq_acc[i]);

      for (int j = 0; j < DEQ_W; j++) w_deq_valid[j] = (int'(r_count) > j);
      w_deq_acc = q_if.deq_ready_i & w_deq_valid;
      w_n_deq   = '0;
      for (int j = 0; j < DEQ_W; j++) w_n_deq = w_n_deq + CNT_W'(w_deq_acc[j]);

      w_deq_data = '0;
      for (int j = 0; j < DEQ_W; j++)
         w_deq_data[j*WIDTH +: WIDTH] = r_mem[ptr_add(r_head, j)];
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= ptr_add(r_head, int'(w_n_deq));
         r_tail  <= ptr_add(r_tail, int'(w_n_enq));
         r_count <= r_count + w_n_enq - w_n_deq;
      end
   end

   // Storage carries no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         for (int i = 0; i < ENQ_W; i++)
            if (w_enq_acc[i]) r_mem[ptr_add(r_tail, i)] <= q_if.enq_data_i[i*WIDTH +: WIDTH];
      end
   end

   assign q_if.enq_ready_o = w_enq_ready;
   assign q_if.deq_valid_o = w_deq_valid;
   assign q_if.deq_data_o  = w_deq_data;
   assign count_o          = r_count;
   assign empty_o          = (r_count == '0);
   assign full_o           = (r_count == CNT_W'(DEPTH));
   assign almost_full_o    = (int'(w_free) <= AFULL_MARGIN);

   a_params: assert property (@(posedge clk)
      (DEPTH >= 2) && (ENQ_W >= 1) && (ENQ_W <= DEPTH) && (DEQ_W >= 1) &&
      (DEQ_W <= DEPTH) && (AFULL_MARGIN >= 0) && (AFULL_MARGIN < DEPTH))
      else $error("multi_port_queue: parameter out of range");

   // A mask is prefix-contiguous exactly when mask & (mask + 1) == 0.
   a_enq_prefix: assert property (@(posedge clk) disable iff (rst)
      (({1'b0, q_if.enq_valid_i} & ({1'b0, q_if.enq_valid_i} + (ENQ_W+1)'(1))) == '0))
      else $error("multi_port_queue: enq_valid_i not prefix-contiguous");

   a_deq_prefix: assert property (@(posedge clk) disable iff (rst)
      (({1'b0, q_if.deq_ready_i} & ({1'b0, q_if.deq_ready_i} + (DEQ_W+1)'(1))) == '0))
      else $error("multi_port_queue: deq_ready_i not prefix-contiguous");
endmodule

// File: tb/tb_multi_port_queue.sv
module tb_multi_port_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       flush_a, flush_b;
   logic [3:0] count_a;
   logic       empty_a, full_a, afull_a;
   logic [2:0] count_b;
   logic       empty_b, full_b, afull_b;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [31:0] exp_a[$];
   logic [15:0] exp_q[$];

   multi_port_queue_if #(.WIDTH(32), .ENQ_W(2), .DEQ_W(2)) q_a ();
   multi_port_queue_if #(.WIDTH(16), .ENQ_W(3), .DEQ_W(2)) q_b ();

   multi_port_queue #(.WIDTH(32), .DEPTH(8), .ENQ_W(2), .DEQ_W(2), .AFULL_MARGIN(2)) dut_a (
      .clk(clk), .rst(rst), .flush_i(flush_a), .q_if(q_a),
      .count_o(count_a), .empty_o(empty_a), .full_o(full_a), .almost_full_o(afull_a));

   multi_port_queue #(.WIDTH(16), .DEPTH(6), .ENQ_W(3), .DEQ_W(2), .AFULL_MARGIN(1)) dut_b (
      .clk(clk), .rst(rst), .flush_i(flush_b), .q_if(q_b),
      .count_o(count_b), .empty_o(empty_b), .full_o(full_b), .almost_full_o(afull_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      q_a.enq_valid_i = '0;
      q_a.enq_data_i  = '0;
      q_a.deq_ready_i = '0;
      flush_a         = 1'b0;
   endtask

   task automatic idle_b();
      q_b.enq_valid_i = '0;
      q_b.enq_data_i  = '0;
      q_b.deq_ready_i = '0;
      flush_b         = 1'b0;
   endtask

   task automatic enq_a(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
      q_a.enq_valid_i = v;
      q_a.enq_data_i  = {d1, d0};
      tick();
      idle_a();
   endtask

   task automatic flush_clear();
      flush_a = 1'b1;
      tick();
      flush_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_a();
      idle_b();
      tick();
      tick();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", count_a); end
      vec_cnt++; if (empty_a !== 1'b1) begin err_cnt++; $display("FAIL reset_empty got=%b exp=1", empty_a); end
      vec_cnt++; if (full_a !== 1'b0) begin err_cnt++; $display("FAIL reset_full got=%b exp=0", full_a); end
      vec_cnt++; if (afull_a !== 1'b0) begin err_cnt++; $display("FAIL reset_afull got=%b exp=0", afull_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b00) begin err_cnt++; $display("FAIL reset_deq_valid got=%b exp=00", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.enq_ready_o !== 2'b11) begin err_cnt++; $display("FAIL reset_enq_ready got=%b exp=11", q_a.enq_ready_o); end
      vec_cnt++; if (q_b.enq_ready_o !== 3'b111) begin err_cnt++; $display("FAIL reset_b_enq_ready got=%b exp=111", q_b.enq_ready_o); end
      rst = 1'b0;
   endtask

   task automatic test_enq_basic();
      q_a.enq_valid_i = 2'b11;
      q_a.enq_data_i  = {32'h22, 32'h11};
      #1;
      vec_cnt++; if (q_a.deq_valid_o !== 2'b00) begin err_cnt++; $display("FAIL no_bypass_valid got=%b exp=00", q_a.deq_valid_o); end
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL no_bypass_count got=%0d exp=0", count_a); end
      tick();
      idle_a();
      vec_cnt++; if (count_a !== 4'd2) begin err_cnt++; $display("FAIL basic_count got=%0d exp=2", count_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b11) begin err_cnt++; $display("FAIL basic_valid got=%b exp=11", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'h11) begin err_cnt++; $display("FAIL basic_lane0 got=%0h exp=11", q_a.deq_data_o[31:0]); end
      vec_cnt++; if (q_a.deq_data_o[63:32] !== 32'h22) begin err_cnt++; $display("FAIL basic_lane1 got=%0h exp=22", q_a.deq_data_o[63:32]); end
      vec_cnt++; if (empty_a !== 1'b0) begin err_cnt++; $display("FAIL basic_empty got=%b exp=0", empty_a); end
      flush_clear();
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         enq_a(2'b11, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k));
         if (k == 1) begin
            vec_cnt++; if (count_a !== 4'd4) begin err_cnt++; $display("FAIL fill_count4 got=%0d exp=4", count_a); end
            vec_cnt++; if (afull_a !== 1'b0) begin err_cnt++; $display("FAIL fill_afull4 got=%b exp=0", afull_a); end
         end
         if (k == 2) begin
            vec_cnt++; if (count_a !== 4'd6) begin err_cnt++; $display("FAIL fill_count6 got=%0d exp=6", count_a); end
            vec_cnt++; if (afull_a !== 1'b1) begin err_cnt++; $display("FAIL fill_afull6 got=%b exp=1", afull_a); end
            vec_cnt++; if (full_a !== 1'b0) begin err_cnt++; $display("FAIL fill_full6 got=%b exp=0", full_a); end
         end
      end
      vec_cnt++; if (count_a !== 4'd8) begin err_cnt++; $display("FAIL fill_count8 got=%0d exp=8", count_a); end
      vec_cnt++; if (full_a !== 1'b1) begin err_cnt++; $display("FAIL fill_full got=%b exp=1", full_a); end
      vec_cnt++; if (q_a.enq_ready_o !== 2'b00) begin err_cnt++; $display("FAIL fill_ready got=%b exp=00", q_a.enq_ready_o); end
      vec_cnt++; if (afull_a !== 1'b1) begin err_cnt++; $display("FAIL fill_afull8 got=%b exp=1", afull_a); end
      enq_a(2'b11, 32'hdead, 32'hbeef);
      vec_cnt++; if (count_a !== 4'd8) begin err_cnt++; $display("FAIL overfill_count got=%0d exp=8", count_a); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'h100) begin err_cnt++; $display("FAIL overfill_lane0 got=%0h exp=100", q_a.deq_data_o[31:0]); end
      vec_cnt++; if (q_a.deq_data_o[63:32] !== 32'h101) begin err_cnt++; $display("FAIL overfill_lane1 got=%0h exp=101", q_a.deq_data_o[63:32]); end
      flush_clear();
      vec_cnt++; if (empty_a !== 1'b1) begin err_cnt++; $display("FAIL fill_flush_empty got=%b exp=1", empty_a); end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      // Move head and tail to 5 through an empty queue.
      enq_a(2'b11, 32'h1, 32'h2);
      enq_a(2'b11, 32'h3, 32'h4);
      enq_a(2'b01, 32'h5, 32'h0);
      q_a.deq_ready_i = 2'b11; tick(); tick();
      q_a.deq_ready_i = 2'b01; tick();
      idle_a();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL wrap_pre_count got=%0d exp=0", count_a); end
      enq_a(2'b11, 32'hA0, 32'hA1);
      enq_a(2'b11, 32'hA2, 32'hA3);
      enq_a(2'b11, 32'hA4, 32'hA5);
      enq_a(2'b01, 32'hA6, 32'h0);
      vec_cnt++; if (count_a !== 4'd7) begin err_cnt++; $display("FAIL wrap_count7 got=%0d exp=7", count_a); end
      vec_cnt++; if (q_a.enq_ready_o !== 2'b01) begin err_cnt++; $display("FAIL wrap_ready got=%b exp=01", q_a.enq_ready_o); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'hA0) begin err_cnt++; $display("FAIL wrap_head got=%0h exp=a0", q_a.deq_data_o[31:0]); end
      q_a.enq_valid_i = 2'b11;
      q_a.enq_data_i  = {32'hB1, 32'hB0};
      q_a.deq_ready_i = 2'b11;
      tick();
      idle_a();
      vec_cnt++; if (count_a !== 4'd6) begin err_cnt++; $display("FAIL wrap_count6 got=%0d exp=6", count_a); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'hA2) begin err_cnt++; $display("FAIL wrap_lane0 got=%0h exp=a2", q_a.deq_data_o[31:0]); end
      vec_cnt++; if (q_a.deq_data_o[63:32] !== 32'hA3) begin err_cnt++; $display("FAIL wrap_lane1 got=%0h exp=a3", q_a.deq_data_o[63:32]); end
      exp_a = {32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hB0};
      for (int c = 0; c < 10 && count_a != 4'd0; c++) begin
         for (int j = 0; j < 2; j++) begin
            if (q_a.deq_valid_o[j]) begin
               e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hxxxxxxxx;
               vec_cnt++;
               if (q_a.deq_data_o[j*32 +: 32] !== e) begin
                  err_cnt++;
                  $display("FAIL wrap_drain lane%0d got=%0h exp=%0h", j, q_a.deq_data_o[j*32 +: 32], e);
               end
            end
         end
         q_a.deq_ready_i = q_a.deq_valid_o;
         tick();
      end
      idle_a();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL wrap_drain_count got=%0d exp=0", count_a); end
      vec_cnt++; if (exp_a.size() != 0) begin err_cnt++; $display("FAIL wrap_drain_left got=%0d exp=0", exp_a.size()); end
      flush_clear();
   endtask

   task automatic test_partial_deq();
      enq_a(2'b11, 32'hC0, 32'hC1);
      enq_a(2'b01, 32'hC2, 32'h0);
      vec_cnt++; if (count_a !== 4'd3) begin err_cnt++; $display("FAIL part_count3 got=%0d exp=3", count_a); end
      q_a.deq_ready_i = 2'b01;
      tick();
      idle_a();
      vec_cnt++; if (count_a !== 4'd2) begin err_cnt++; $display("FAIL part_count2 got=%0d exp=2", count_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b11) begin err_cnt++; $display("FAIL part_valid got=%b exp=11", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'hC1) begin err_cnt++; $display("FAIL part_lane0 got=%0h exp=c1", q_a.deq_data_o[31:0]); end
      vec_cnt++; if (q_a.deq_data_o[63:32] !== 32'hC2) begin err_cnt++; $display("FAIL part_lane1 got=%0h exp=c2", q_a.deq_data_o[63:32]); end
      flush_clear();
   endtask

   task automatic test_flush();
      enq_a(2'b11, 32'hD0, 32'hD1);
      enq_a(2'b11, 32'hD2, 32'hD3);
      enq_a(2'b01, 32'hD4, 32'h0);
      vec_cnt++; if (count_a !== 4'd5) begin err_cnt++; $display("FAIL flush_pre_count got=%0d exp=5", count_a); end
      vec_cnt++; if (empty_a !== 1'b0) begin err_cnt++; $display("FAIL flush_pre_empty got=%b exp=0", empty_a); end
      flush_a         = 1'b1;
      q_a.enq_valid_i = 2'b11;
      q_a.enq_data_i  = {32'hE1, 32'hE0};
      q_a.deq_ready_i = 2'b11;
      tick();
      idle_a();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL flush_count got=%0d exp=0", count_a); end
      vec_cnt++; if (empty_a !== 1'b1) begin err_cnt++; $display("FAIL flush_empty got=%b exp=1", empty_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b00) begin err_cnt++; $display("FAIL flush_valid got=%b exp=00", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.enq_ready_o !== 2'b11) begin err_cnt++; $display("FAIL flush_ready got=%b exp=11", q_a.enq_ready_o); end
      enq_a(2'b01, 32'h33, 32'h0);
      vec_cnt++; if (count_a !== 4'd1) begin err_cnt++; $display("FAIL post_flush_count got=%0d exp=1", count_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b01) begin err_cnt++; $display("FAIL post_flush_valid got=%b exp=01", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.deq_data_o[31:0] !== 32'h33) begin err_cnt++; $display("FAIL post_flush_lane0 got=%0h exp=33", q_a.deq_data_o[31:0]); end
      flush_clear();
   endtask

   task automatic test_rst_mid();
      enq_a(2'b11, 32'hF0, 32'hF1);
      enq_a(2'b11, 32'hF2, 32'hF3);
      enq_a(2'b01, 32'hF4, 32'h0);
      vec_cnt++; if (count_a !== 4'd5) begin err_cnt++; $display("FAIL rst_mid_pre got=%0d exp=5", count_a); end
      rst             = 1'b1;
      q_a.enq_valid_i = 2'b11;
      q_a.deq_ready_i = 2'b11;
      tick();
      rst = 1'b0;
      idle_a();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL rst_mid_count got=%0d exp=0", count_a); end
      vec_cnt++; if (empty_a !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_empty got=%b exp=1", empty_a); end
      vec_cnt++; if (full_a !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_full got=%b exp=0", full_a); end
      vec_cnt++; if (afull_a !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_afull got=%b exp=0", afull_a); end
      vec_cnt++; if (q_a.deq_valid_o !== 2'b00) begin err_cnt++; $display("FAIL rst_mid_valid got=%b exp=00", q_a.deq_valid_o); end
      vec_cnt++; if (q_a.enq_ready_o !== 2'b11) begin err_cnt++; $display("FAIL rst_mid_ready got=%b exp=11", q_a.enq_ready_o); end
      tick();
      vec_cnt++; if (count_a !== 4'd0) begin err_cnt++; $display("FAIL rst_mid_hold got=%0d exp=0", count_a); end
   endtask

   // DEPTH=6, ENQ_W=3: alternating fill-heavy and drain-heavy phases against
   // a queue model, crossing the non-power-of-two wrap many times.
   task automatic test_cyclic_b();
      int ne_req, nd_req, free, n_enq, n_deq;
      logic [2:0] er;
      logic [1:0] ev;
      exp_q = {};
      for (int c = 0; c < 100; c++) begin
         if (((c / 10) % 2) == 0) begin ne_req = (c % 3) + 1; nd_req = c % 2; end
         else begin ne_req = c % 2; nd_req = 2; end
         free = 6 - exp_q.size();
         for (int i = 0; i < 3; i++) er[i] = (free > i);
         for (int j = 0; j < 2; j++) ev[j] = (exp_q.size() > j);
         vec_cnt++; if (count_b !== 3'(exp_q.size())) begin err_cnt++; $display("FAIL cyc_count c=%0d got=%0d exp=%0d", c, count_b, exp_q.size()); end
         vec_cnt++; if (q_b.enq_ready_o !== er) begin err_cnt++; $display("FAIL cyc_ready c=%0d got=%b exp=%b", c, q_b.enq_ready_o, er); end
         vec_cnt++; if (q_b.deq_valid_o !== ev) begin err_cnt++; $display("FAIL cyc_valid c=%0d got=%b exp=%b", c, q_b.deq_valid_o, ev); end
         for (int j = 0; j < 2; j++) begin
            if (j < exp_q.size()) begin
               vec_cnt++;
               if (q_b.deq_data_o[j*16 +: 16] !== exp_q[j]) begin
                  err_cnt++;
                  $display("FAIL cyc_data c=%0d lane%0d got=%0h exp=%0h", c, j, q_b.deq_data_o[j*16 +: 16], exp_q[j]);
               end
            end
         end
         q_b.enq_valid_i = 3'((1 << ne_req) - 1);
         for (int i = 0; i < 3; i++) q_b.enq_data_i[i*16 +: 16] = 16'(c * 8 + i);
         q_b.deq_ready_i = 2'((1 << nd_req) - 1);
         tick();
         n_deq = (nd_req < exp_q.size()) ? nd_req : exp_q.size();
         n_enq = (ne_req < free) ? ne_req : free;
         for (int j = 0; j < n_deq; j++) void'(exp_q.pop_front());
         for (int i = 0; i < n_enq; i++) exp_q.push_back(16'(c * 8 + i));
      end
      idle_b();
   endtask

   initial begin
      rst = 1'b1;
      idle_a();
      idle_b();
      test_reset();
      test_enq_basic();
      test_fill();
      test_wrap();
      test_partial_deq();
      test_flush();
      test_rst_mid();
      test_cyclic_b();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
